// File: rtl/slave_pkg.sv
// slave_pkg: shared FSM state type, wait-counter width and default slave constants
package slave_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  localparam int CNT_W = 4;
  localparam logic [31:0] DEF_RD = 32'hDEAD_BEEF;
  localparam logic [31:0] DEF_BASE = 32'h0000_1000;
endpackage

// File: rtl/bus_if.sv
// bus_if: valid/ready bus; master drives valid, read, addr, write_data; slave drives ready, read_data
interface bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic valid;
  logic read;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic ready;
  logic [DATA_W-1:0] read_data;
  modport master (output valid, read, addr, write_data, input ready, read_data);
  modport slave (input valid, read, addr, write_data, output ready, read_data);
endinterface

// File: rtl/slave_addr_decode.sv
// slave_addr_decode: byte address in -> register index hit and dec_err (misaligned, below base, or past last register)
module slave_addr_decode #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_1000),
  localparam int IDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  hit,
  output logic              dec_err
);
  localparam int BYTES = DATA_W / 8;
  logic [ADDR_W-1:0] idx;
  assign idx = (addr - BASE_ADDR) / ADDR_W'(BYTES);
  assign dec_err = addr < BASE_ADDR || (addr % ADDR_W'(BYTES)) != '0 || idx >= ADDR_W'(NUM_REGS);
  assign hit = idx[IDX_W-1:0];
endmodule

// File: rtl/slave_regfile.sv
// slave_regfile: wait-stated register slave; in clk, reset (sync, low), busc slave, hw_status; out reg_q, wr_pulse, err
module slave_regfile
  import slave_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NUM_REGS = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE),
  parameter int WAIT_STATES = 1,
  parameter logic [NUM_REGS-1:0] RO_MASK = NUM_REGS'(8'hC0),
  parameter logic [DATA_W-1:0] DEFAULT_RD = DATA_W'(DEF_RD)
) (
  input  logic                       clk,
  input  logic                       reset,
  bus_if.slave                       busc,
  input  logic [NUM_REGS*DATA_W-1:0] hw_status,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        wr_pulse,
  output logic                       err
);
  localparam int IDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic read_q, read_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_r;
  logic [IDX_W-1:0] hit;
  logic dec_err, ro_hit, commit, wr_en, ready_r, idle;
  // zero-wait commits happen in ST_IDLE, before the latch holds the request
  assign idle = state == ST_IDLE;
  assign addr_d = idle ? busc.addr : addr_q;
  assign read_d = idle ? busc.read : read_q;
  assign wdata_d = idle ? busc.write_data : wdata_q;
  slave_addr_decode #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR)
  ) u_dec (
    .addr(addr_d), .hit(hit), .dec_err(dec_err)
  );
  assign ro_hit = !dec_err && RO_MASK[hit];
  assign wr_en = commit && !read_d && !dec_err && !ro_hit;
  assign busc.ready = ready_r;
  assign busc.read_data = rdata_r;
  always_comb begin
    commit = busc.valid && ((idle && WAIT_STATES == 0) || (state == ST_WAIT && cnt == '0));
    nxt = state == ST_RESP || !busc.valid ? ST_IDLE :
          idle ? (WAIT_STATES == 0 ? ST_RESP : ST_WAIT) :
          cnt == '0 ? ST_RESP : ST_WAIT;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      addr_q <= '0;
      read_q <= 1'b0;
      wdata_q <= '0;
      reg_q <= '0;
      wr_pulse <= '0;
      err <= 1'b0;
      ready_r <= 1'b0;
      rdata_r <= '0;
    end else begin
      state <= nxt;
      if (idle && busc.valid) begin
        addr_q <= busc.addr;
        read_q <= busc.read;
        wdata_q <= busc.write_data;
        cnt <= CNT_W'(WAIT_STATES - 1);
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      ready_r <= commit;
      err <= commit && (dec_err || (!read_d && ro_hit));
      wr_pulse <= wr_en ? NUM_REGS'(1) << hit : '0;
      if (wr_en) reg_q[hit*DATA_W +: DATA_W] <= wdata_d;
      if (commit && (read_d || dec_err))
        rdata_r <= dec_err ? DEFAULT_RD : ro_hit ? hw_status[hit*DATA_W +: DATA_W] : reg_q[hit*DATA_W +: DATA_W];
    end
  end
endmodule

// File: tb/tb_slave_regfile.sv
// tb_slave_regfile: scoreboard bench for slave_regfile at WAIT_STATES 1 (main), 0 and 3
module tb_slave_regfile;
  logic clk = 1'b0, reset = 1'b0, valid = 1'b0, read = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [255:0] hw_status = '0, q0, q1, q3;
  logic [7:0] wp0, wp1, wp3;
  logic e0, e1, e3;
  int vectors = 0, miscompares = 0;
  typedef struct {logic [31:0] rd; logic err; logic [7:0] wp;} exp_t;
  exp_t sb[$];
  logic [31:0] mregs [8];
  logic [31:0] last_rd = '0;
  always #5 clk = ~clk;
  bus_if #(.ADDR_W(32), .DATA_W(32)) b0 (), b1 (), b3 ();
  assign b0.valid = valid;
  assign b0.read = read;
  assign b0.addr = addr;
  assign b0.write_data = wdata;
  assign b1.valid = valid;
  assign b1.read = read;
  assign b1.addr = addr;
  assign b1.write_data = wdata;
  assign b3.valid = valid;
  assign b3.read = read;
  assign b3.addr = addr;
  assign b3.write_data = wdata;
  slave_regfile #(.WAIT_STATES(1)) dut1 (.clk(clk), .reset(reset), .busc(b1), .hw_status(hw_status),
                                         .reg_q(q1), .wr_pulse(wp1), .err(e1));
  slave_regfile #(.WAIT_STATES(0)) dut0 (.clk(clk), .reset(reset), .busc(b0), .hw_status(hw_status),
                                         .reg_q(q0), .wr_pulse(wp0), .err(e0));
  slave_regfile #(.WAIT_STATES(3)) dut3 (.clk(clk), .reset(reset), .busc(b3), .hw_status(hw_status),
                                         .reg_q(q3), .wr_pulse(wp3), .err(e3));
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [255:0] mflat();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = mregs[i];
    return v;
  endfunction
  // reference model: decode the address independently and predict the response
  task automatic push(input logic [31:0] a, input logic r, input logic [31:0] wd);
    exp_t e;
    logic [31:0] off;
    int idx;
    e.err = 1'b0;
    e.wp = '0;
    e.rd = last_rd;
    off = a - 32'h1000;
    if (a < 32'h1000 || a[1:0] != 2'b00 || off[31:2] >= 30'd8) begin
      e.err = 1'b1;
      e.rd = 32'hDEAD_BEEF;
    end else begin
      idx = int'(off[4:2]);
      if (r) e.rd = idx >= 6 ? hw_status[idx*32 +: 32] : mregs[idx];
      else if (idx >= 6) e.err = 1'b1;
      else begin
        mregs[idx] = wd;
        e.wp = 8'(1 << idx);
      end
    end
    last_rd = e.rd;
    sb.push_back(e);
  endtask
  task automatic xact(input string tag, input logic [31:0] a, input logic r, input logic [31:0] wd);
    exp_t e;
    int lat = 0;
    push(a, r, wd);
    addr = a;
    read = r;
    wdata = wd;
    valid = 1'b1;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (b1.ready) lat = i;
    end
    e = sb.pop_front();
    chk({tag, ".latency"}, 256'(lat), 256'(2));
    chk({tag, ".read_data"}, 256'(b1.read_data), 256'(e.rd));
    chk({tag, ".err"}, 256'(e1), 256'(e.err));
    chk({tag, ".wr_pulse"}, 256'(wp1), 256'(e.wp));
    chk({tag, ".reg_q"}, q1, mflat());
    valid = 1'b0;
    @(negedge clk);
    chk({tag, ".ready_drop"}, 256'(b1.ready), 256'(0));
    chk({tag, ".pulse_drop"}, 256'({e1, wp1}), 256'(0));
  endtask
  initial begin
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst.ready", 256'({b0.ready, b1.ready, b3.ready}), 256'(0));
    chk("rst.read_data", 256'(b1.read_data), 256'(0));
    chk("rst.err_pulse", 256'({e0, e1, e3, wp0, wp1, wp3}), 256'(0));
    chk("rst.reg_q", q1, 256'(0));
    xact("wr2", 32'h1008, 1'b0, 32'hA5A5_0001);
    xact("rd2", 32'h1008, 1'b1, 32'h0);
    hw_status[7*32 +: 32] = 32'h0000_BEEF;
    hw_status[6*32 +: 32] = 32'h1357_9BDF;
    xact("rd_ro7", 32'h101C, 1'b1, 32'h0);
    xact("rd_ro6", 32'h1018, 1'b1, 32'h0);
    xact("wr_ro7", 32'h101C, 1'b0, 32'h1);
    xact("wr5", 32'h1014, 1'b0, 32'hCAFE_0005);
    xact("rd_oob", 32'h1020, 1'b1, 32'h0);
    xact("rd_mis", 32'h1002, 1'b1, 32'h0);
    xact("rd_low", 32'h0FFC, 1'b1, 32'h0);
    xact("rd5", 32'h1014, 1'b1, 32'h0);
    addr = 32'h1004;
    read = 1'b0;
    wdata = 32'h7777_7777;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort.ready", 256'({b1.ready, e1, wp1}), 256'(0));
    end
    chk("abort.reg_q", q1, mflat());
    addr = 32'h100C;
    wdata = 32'h5555_5555;
    valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    valid = 1'b0;
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    last_rd = '0;
    repeat (2) begin
      @(negedge clk);
      chk("rstmid.ready", 256'({b1.ready, e1, wp1}), 256'(0));
    end
    chk("rstmid.reg_q", q1, mflat());
    xact("wr3", 32'h100C, 1'b0, 32'h1234_5678);
    xact("rd3", 32'h100C, 1'b1, 32'h0);
    @(negedge clk);
    addr = 32'h1000;
    read = 1'b0;
    wdata = 32'h0000_00AA;
    valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("ws0.ready%0d", k), 256'(b0.ready), 256'(k % 2 == 1));
      chk($sformatf("ws1.ready%0d", k), 256'(b1.ready), 256'(k % 3 == 2));
      chk($sformatf("ws3.ready%0d", k), 256'(b3.ready), 256'(k % 5 == 4));
    end
    valid = 1'b0;
    chk("ws0.reg0", 256'(q0[31:0]), 256'(32'h0000_00AA));
    chk("ws3.reg0", 256'(q3[31:0]), 256'(32'h0000_00AA));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
